pipe_cmult: RTL and testbench

PIPE_CMULT -- requirements
Module: pipe_cmult

---
 rtl/pipe_cmult_pkg.sv | 10 +
 rtl/cmult_rndsat.sv | 54 +++++
 rtl/pipe_cmult.sv | 142 ++++++++++++++
 tb/tb_pipe_cmult.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_cmult_pkg.sv
// Shared constants for the pipelined complex multiplier.
// Latency: none (constants only).
// Backpressure: none (constants only).
package pipe_cmult_pkg;

    localparam int CMULT_DW     = 16;
    localparam int CMULT_FRAC   = 15;
    localparam int CMULT_STAGES = 3;

endpackage

// File: rtl/cmult_rndsat.sv
// Rounds one 2*DW+1-bit Q-format sum half-up, then clips (CMULT_SAT_EN) or wraps it to DW bits.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage owns flow control.
module cmult_rndsat
    import pipe_cmult_pkg::*;
#(
    parameter int DW   = CMULT_DW,
    parameter int FRAC = CMULT_FRAC
) (
    input  logic [2*DW:0]  sum,
    output logic [DW-1:0]  res,
    output logic           clip
);

    // One guard bit above the sum so adding the rounding constant can never overflow.
    localparam int         W   = 2*DW + 2;
    localparam logic [W-1:0] RND = W'(1) << (FRAC - 1);

    logic [W-1:0]        ext;
    logic signed [W-1:0] rounded;
    logic signed [W-1:0] shifted;

    assign ext     = {sum[2*DW], sum};
    assign rounded = ext + RND;
    assign shifted = rounded >>> FRAC;

`ifdef CMULT_SAT_EN
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [W-DW:0] hi;
    logic          fits;

    // The value fits in DW bits when everything from the DW-bit sign bit upward agrees.
    assign hi   = shifted[W-1:DW-1];
    assign fits = (&hi) | ~(|hi);

    always_comb begin
        res  = shifted[DW-1:0];
        clip = 1'b0;
        if (!fits) begin
            res  = shifted[W-1] ? SAT_MIN : SAT_MAX;
            clip = 1'b1;
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^shifted[W-1:DW];
    assign res       = shifted[DW-1:0];
    assign clip      = 1'b0;
`endif

endmodule

// File: rtl/pipe_cmult.sv
// Three-stage complex multiplier A*B or A*conj(B) in Q(DW,FRAC); clip vs wrap chosen by CMULT_SAT_EN.
// Latency: 3 clk edges from input handshake to out_valid, one beat per cycle.
// Backpressure: whole pipe stalls when out_valid && !out_ready; in_ready mirrors that enable.
module pipe_cmult
    import pipe_cmult_pkg::*;
#(
    parameter int DW   = CMULT_DW,
    parameter int FRAC = CMULT_FRAC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] op1,
    input  logic [2*DW-1:0] op2,
    input  logic            conj,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] opr,
    output logic            ovf
);

    localparam int PW = 2*DW;

    logic                    en;
    logic [CMULT_STAGES-1:0] vld;

    // Bubbles stay in place as invalid stages; the pipe only moves as a whole.
    assign en        = !vld[CMULT_STAGES-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld[CMULT_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[CMULT_STAGES-2:0], in_valid};
        end
    end

    // Stage 1: operands and mode.
    logic [PW-1:0] s1_op1;
    logic [PW-1:0] s1_op2;
    logic          s1_conj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op1  <= '0;
            s1_op2  <= '0;
            s1_conj <= 1'b0;
        end else if (en) begin
            s1_op1  <= op1;
            s1_op2  <= op2;
            s1_conj <= conj;
        end
    end

    // Components sign-extended to full product width so each product is exact in PW bits.
    logic signed [PW-1:0] ar_x;
    logic signed [PW-1:0] ai_x;
    logic signed [PW-1:0] br_x;
    logic signed [PW-1:0] bi_x;

    assign ar_x = {{DW{s1_op1[PW-1]}}, s1_op1[PW-1:DW]};
    assign ai_x = {{DW{s1_op1[DW-1]}}, s1_op1[DW-1:0]};
    assign br_x = {{DW{s1_op2[PW-1]}}, s1_op2[PW-1:DW]};
    assign bi_x = {{DW{s1_op2[DW-1]}}, s1_op2[DW-1:0]};

    // Stage 2: four partial products.
    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] p_ir;
    logic                 s2_conj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rr    <= '0;
            p_ii    <= '0;
            p_ri    <= '0;
            p_ir    <= '0;
            s2_conj <= 1'b0;
        end else if (en) begin
            p_rr    <= ar_x * br_x;
            p_ii    <= ai_x * bi_x;
            p_ri    <= ar_x * bi_x;
            p_ir    <= ai_x * br_x;
            s2_conj <= s1_conj;
        end
    end

    logic signed [PW:0] x_rr;
    logic signed [PW:0] x_ii;
    logic signed [PW:0] x_ri;
    logic signed [PW:0] x_ir;
    logic signed [PW:0] re_sum;
    logic signed [PW:0] im_sum;

    assign x_rr = {p_rr[PW-1], p_rr};
    assign x_ii = {p_ii[PW-1], p_ii};
    assign x_ri = {p_ri[PW-1], p_ri};
    assign x_ir = {p_ir[PW-1], p_ir};

    // conj(B) negates bi, which flips the sign of every term that uses it.
    assign re_sum = s2_conj ? (x_rr + x_ii) : (x_rr - x_ii);
    assign im_sum = s2_conj ? (x_ir - x_ri) : (x_ri + x_ir);

    logic [DW-1:0] re_res;
    logic [DW-1:0] im_res;
    logic          re_clip;
    logic          im_clip;

    cmult_rndsat #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_rndsat_re (
        .sum  (re_sum),
        .res  (re_res),
        .clip (re_clip)
    );

    cmult_rndsat #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_rndsat_im (
        .sum  (im_sum),
        .res  (im_res),
        .clip (im_clip)
    );

    // Stage 3: rounded result, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opr <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            opr <= {re_res, im_res};
            ovf <= re_clip | im_clip;
        end
    end

endmodule

// File: tb/tb_pipe_cmult.sv
// Bench for pipe_cmult at DW=16, FRAC=15; expected results come from a behavioural model or fixed vectors.
module tb_pipe_cmult;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] op1       = '0;
    logic [31:0] op2       = '0;
    logic        conj      = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] opr;
    logic        ovf;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_cmult #(
        .DW   (16),
        .FRAC (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .conj      (conj),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opr       (opr),
        .ovf       (ovf)
    );

    function automatic logic [16:0] reduce(longint v);
        longint r;
        r = (v + 16384) >>> 15;
`ifdef CMULT_SAT_EN
        if (r > 32767)  return {1'b1, 16'h7fff};
        if (r < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, r[15:0]};
    endfunction

    function automatic logic [32:0] model(logic [31:0] a, logic [31:0] b, logic c);
        longint ar, ai, br, bi, re, im;
        logic [16:0] rr, ri;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        re = c ? (ar*br + ai*bi) : (ar*br - ai*bi);
        im = c ? (ai*br - ar*bi) : (ar*bi + ai*br);
        rr = reduce(re);
        ri = reduce(im);
        return {rr[16] | ri[16], rr[15:0], ri[15:0]};
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 3))
            0:       return 32'h8000_8000;
            1:       return 32'h7fff_7fff;
            default: return $urandom();
        endcase
    endfunction

    // Advances one cycle: samples handshakes and outputs at the falling edge, returns #1 after the rising edge.
    task automatic step(output logic acc, output logic got, output logic v, output logic rdy,
                        output logic [31:0] g_opr, output logic g_ovf);
        @(negedge clk);
        acc   = in_valid && in_ready;
        got   = out_valid && out_ready;
        v     = out_valid;
        rdy   = in_ready;
        g_opr = opr;
        g_ovf = ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (opr !== 32'h0) begin errors++; $display("FAIL reset_opr: got %h expected 00000000", opr); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        logic acc, got, v, rdy, g_ovf;
        logic [31:0] g_opr;
        logic [32:0] e;
        out_ready = 1'b1;
        op1 = 32'h4000_4000; op2 = 32'h4000_0000; conj = 1'b0; in_valid = 1'b1;
        step(acc, got, v, rdy, g_opr, g_ovf);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL lat_accept: got %b expected 1", acc); end
        if (acc) exp_q.push_back(model(32'h4000_4000, 32'h4000_0000, 1'b0));
        in_valid = 1'b0;
        step(acc, got, v, rdy, g_opr, g_ovf);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid %b after 2 edges, expected 0", out_valid); end
        step(acc, got, v, rdy, g_opr, g_ovf);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: out_valid %b after 3 edges, expected 1", out_valid); end
        checks++;
        if (opr !== 32'h2000_2000) begin errors++; $display("FAIL lat_opr: got %h expected 20002000", opr); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL lat_ovf: got %b expected 0", ovf); end
        step(acc, got, v, rdy, g_opr, g_ovf);
        if (got) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL lat_sb: unexpected output %h", g_opr); end
            else begin
                e = exp_q.pop_front();
                if ({g_ovf, g_opr} !== e) begin errors++; $display("FAIL lat_sb: got %h expected %h", {g_ovf, g_opr}, e); end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL lat_drain: %0d results missing, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_vectors();
        logic acc, got, v, rdy, g_ovf;
        logic [31:0] g_opr;
        logic [32:0] e;
        logic [31:0] t_op1[5];
        logic [31:0] t_op2[5];
        logic        t_conj[5];
        logic [32:0] t_exp[5];
        int idx, nrecv;
        t_op1[0] = 32'h4000_4000; t_op2[0] = 32'h4000_0000; t_conj[0] = 1'b0; t_exp[0] = {1'b0, 32'h2000_2000};
        t_op1[1] = 32'h0000_4000; t_op2[1] = 32'h0000_4000; t_conj[1] = 1'b1; t_exp[1] = {1'b0, 32'h2000_0000};
        t_op1[2] = 32'h0000_4000; t_op2[2] = 32'h0000_4000; t_conj[2] = 1'b0; t_exp[2] = {1'b0, 32'he000_0000};
`ifdef CMULT_SAT_EN
        t_op1[3] = 32'h8000_0000; t_op2[3] = 32'h8000_0000; t_conj[3] = 1'b0; t_exp[3] = {1'b1, 32'h7fff_0000};
`else
        t_op1[3] = 32'h8000_0000; t_op2[3] = 32'h8000_0000; t_conj[3] = 1'b0; t_exp[3] = {1'b0, 32'h8000_0000};
`endif
        t_op1[4] = 32'h0001_0000; t_op2[4] = 32'h4000_0000; t_conj[4] = 1'b0; t_exp[4] = {1'b0, 32'h0001_0000};
        idx = 0; nrecv = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && nrecv < 5; cyc++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin op1 = t_op1[idx]; op2 = t_op2[idx]; conj = t_conj[idx]; end
            step(acc, got, v, rdy, g_opr, g_ovf);
            if (acc) begin exp_q.push_back(t_exp[idx]); idx++; end
            if (got) begin
                nrecv++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL vec_sb: unexpected output %h", g_opr); end
                else begin
                    e = exp_q.pop_front();
                    if ({g_ovf, g_opr} !== e) begin errors++; $display("FAIL vec_%0d: got %h expected %h", nrecv - 1, {g_ovf, g_opr}, e); end
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nrecv != 5) begin errors++; $display("FAIL vec_count: got %0d results expected 5", nrecv); end
        exp_q.delete();
    endtask

    task automatic test_stall_stream();
        logic acc, got, v, rdy, g_ovf, ordy;
        logic [31:0] g_opr, held;
        logic [32:0] e;
        logic [31:0] a[8];
        logic [31:0] b[8];
        logic        c[8];
        int idx, nrecv;
        for (int i = 0; i < 8; i++) begin a[i] = pick_op(); b[i] = pick_op(); c[i] = 1'($urandom_range(0, 1)); end
        idx = 0; nrecv = 0; held = '0;
        for (int cyc = 0; cyc < 60 && nrecv < 8; cyc++) begin
            ordy      = !(cyc >= 4 && cyc <= 6);
            out_ready = ordy;
            in_valid  = (idx < 8);
            if (idx < 8) begin op1 = a[idx]; op2 = b[idx]; conj = c[idx]; end
            step(acc, got, v, rdy, g_opr, g_ovf);
            checks++;
            if (rdy !== ordy) begin errors++; $display("FAIL stall_in_ready c%0d: got %b expected %b", cyc, rdy, ordy); end
            if (cyc == 4) held = g_opr;
            if (cyc == 5 || cyc == 6) begin
                checks++;
                if (v !== 1'b1 || g_opr !== held) begin
                    errors++; $display("FAIL stall_hold c%0d: valid %b opr %h expected valid 1 opr %h", cyc, v, g_opr, held);
                end
            end
            if (acc) begin exp_q.push_back(model(a[idx], b[idx], c[idx])); idx++; end
            if (got) begin
                nrecv++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL stall_sb: unexpected output %h", g_opr); end
                else begin
                    e = exp_q.pop_front();
                    if ({g_ovf, g_opr} !== e) begin errors++; $display("FAIL stall_beat%0d: got %h expected %h", nrecv - 1, {g_ovf, g_opr}, e); end
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (nrecv != 8 || exp_q.size() != 0) begin
            errors++; $display("FAIL stall_count: got %0d results, %0d pending, expected 8 and 0", nrecv, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic acc, got, v, rdy, g_ovf;
        logic [31:0] g_opr;
        logic [32:0] e;
        int nsent, nrecv;
        nsent = 0; nrecv = 0;
        op1 = pick_op(); op2 = pick_op(); conj = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 600 && nrecv < 40; cyc++) begin
            in_valid  = (nsent < 40) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step(acc, got, v, rdy, g_opr, g_ovf);
            if (acc) begin
                exp_q.push_back(model(op1, op2, conj));
                nsent++;
                op1 = pick_op(); op2 = pick_op(); conj = 1'($urandom_range(0, 1));
            end
            if (got) begin
                nrecv++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rand_sb: unexpected output %h", g_opr); end
                else begin
                    e = exp_q.pop_front();
                    if ({g_ovf, g_opr} !== e) begin errors++; $display("FAIL rand_beat%0d: got %h expected %h", nrecv - 1, {g_ovf, g_opr}, e); end
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (nrecv != 40) begin errors++; $display("FAIL rand_count: got %0d results expected 40", nrecv); end
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic acc, got, v, rdy, g_ovf;
        logic [31:0] g_opr;
        int stale;
        out_ready = 1'b0;
        op1 = 32'h4000_4000; op2 = 32'h4000_0000; conj = 1'b0;
        in_valid = 1'b1;
        repeat (2) step(acc, got, v, rdy, g_opr, g_ovf);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) step(acc, got, v, rdy, g_opr, g_ovf);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++;
        if (opr !== 32'h0) begin errors++; $display("FAIL rst_mid_opr: got %h expected 00000000", opr); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b expected 0", ovf); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            step(acc, got, v, rdy, g_opr, g_ovf);
            if (v) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL rst_stale: got %0d stale beats expected 0", stale); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_stall_stream();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
